// File: rtl/std_fp_mult_pipe_cfg.sv
// Unsigned fixed-point multiplier with go/done handshake, configurable latency,
// truncate/round selection and wrap/saturate overflow handling.
module std_fp_mult_pipe_cfg #(
   parameter int WIDTH      = 32,
   parameter int INT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 16,
   parameter int LATENCY    = 3,
   parameter int ROUND      = 0,
   parameter int SATURATE   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             done,
   output logic [1:0]       dbg_state_o
);

   // Handshake: go is sampled in IDLE to start and must stay high through the
   // done cycle; go low in any RUN cycle aborts without touching out/overflow.
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   generate
      if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_chk_width
         $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
      end
      if (LATENCY < 2) begin : g_chk_lat
         $error("LATENCY must be at least 2");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             ovf_q, ovf_d;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     rnd;
   logic               hi_nz;
   logic               res_ovf;
   logic [WIDTH-1:0]   res;

   assign prod = {{WIDTH{1'b0}}, lhs_q} * {{WIDTH{1'b0}}, rhs_q};

   generate
      if (ROUND != 0 && FRAC_WIDTH > 0) begin : g_round
         assign rnd = {1'b0, prod[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH]}
                    + {{WIDTH{1'b0}}, prod[FRAC_WIDTH-1]};
      end else begin : g_trunc
         assign rnd = {1'b0, prod[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH]};
      end
      if (INT_WIDTH > 0) begin : g_hi
         assign hi_nz = |prod[2*WIDTH-1:WIDTH+FRAC_WIDTH];
      end else begin : g_no_hi
         assign hi_nz = 1'b0;
      end
      if (FRAC_WIDTH > 0) begin : g_low
         logic unused_low_bits;
         assign unused_low_bits = ^prod[FRAC_WIDTH-1:0];
      end
   endgenerate

   // Overflow covers both the discarded integer bits and the rounding carry.
   assign res_ovf = hi_nz | rnd[WIDTH];
   assign res     = (res_ovf && SATURATE != 0) ? {WIDTH{1'b1}} : rnd[WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lhs_d   = lhs_q;
      rhs_d   = rhs_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               lhs_d   = left;
               rhs_d   = right;
               cnt_d   = CW'(1);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!go) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == LAST) begin
               out_d   = res;
               ovf_d   = res_ovf;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lhs_q   <= '0;
         rhs_q   <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lhs_q   <= lhs_d;
         rhs_q   <= rhs_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out         = out_q;
   assign overflow    = ovf_q;
   assign dbg_state_o = state_q;

endmodule
